evm_push_fetch: RTL and testbench

// - Sequential PUSH0..PUSH32 executor. It sits between the decode stage, the code-memory

---
 rtl/evm_pkg.sv | 21 ++
 rtl/push_byte_packer.sv | 36 +++
 rtl/evm_push_fetch.sv | 132 +++++++++++++
 tb/tb_evm_push_fetch.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared opcode, gas and state definitions for the PUSH executor.
// Used by the fetch FSM and its byte packer.
package evm_pkg;

  localparam logic [7:0] OP_PUSH0  = 8'h5F;
  localparam logic [7:0] OP_PUSH32 = 8'h7F;

  localparam int GAS_BASE    = 2;
  localparam int GAS_VERYLOW = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PUSH
  } push_state_t;

  function automatic logic is_push(input logic [7:0] op);
    return (op >= OP_PUSH0) && (op <= OP_PUSH32);
  endfunction

endpackage

// File: rtl/push_byte_packer.sv
// Shifts up to FETCH_BYTES code bytes into the immediate accumulator,
// byte 0 first, with bytes at or past code end forced to zero.
module push_byte_packer #(
  parameter int WORD_W      = 256,
  parameter int FETCH_BYTES = 4,
  parameter int PC_W        = 16,
  localparam int CW         = $clog2(FETCH_BYTES + 1)
) (
  input  logic [WORD_W-1:0]        acc,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  input  logic [CW-1:0]            c,
  input  logic [PC_W-1:0]          addr,
  input  logic [PC_W-1:0]          code_size,
  output logic [WORD_W-1:0]        acc_nxt
);

  logic [7:0]      b;
  logic [PC_W-1:0] ba;

  always_comb begin
    acc_nxt = acc;
    b       = '0;
    ba      = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      if (CW'(i) < c) begin
        // address wraps before the code_size compare
        ba = addr + PC_W'(i);
        b  = fetch_data[8*i +: 8];
        if (ba >= code_size)
          b = '0;
        acc_nxt = (acc_nxt << 8) | WORD_W'(b);
      end
    end
  end

endmodule

// File: rtl/evm_push_fetch.sv
// Sequential PUSH0..PUSH32 executor: fetches immediate bytes in chunks,
// assembles them big-endian and hands one push to the stack.
module evm_push_fetch
  import evm_pkg::*;
#(
  parameter int WORD_W      = 256,
  parameter int FETCH_BYTES = 4,
  parameter int PC_W        = 16,
  parameter int GAS_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [7:0]               opcode,
  input  logic [PC_W-1:0]          pc,
  input  logic [PC_W-1:0]          code_size,
  output logic                     fetch_req,
  output logic [PC_W-1:0]          fetch_addr,
  input  logic                     fetch_ack,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  output logic                     push_valid,
  input  logic                     push_ready,
  output logic [WORD_W-1:0]        push_data,
  output logic [PC_W-1:0]          pc_nxt,
  output logic [GAS_W-1:0]         gas,
  output logic                     bad_op
);

  localparam int CW = $clog2(FETCH_BYTES + 1);

  push_state_t       state;
  logic [5:0]        rem;
  logic [PC_W-1:0]   addr;
  logic [PC_W-1:0]   code_sz;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_nxt;
  logic [CW-1:0]     c;
  logic [5:0]        n_in;
  logic              live;
  logic              advance;

  assign n_in = 6'(opcode - OP_PUSH0);

  always_comb begin
    if (rem < 6'(FETCH_BYTES))
      c = CW'(rem);
    else
      c = CW'(FETCH_BYTES);
  end

  // a chunk lying wholly past code end needs no memory request
  always_comb begin
    live = 1'b0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      if ((CW'(i) < c) && ((addr + PC_W'(i)) < code_sz))
        live = 1'b1;
    end
  end

  assign op_ready   = (state == IDLE);
  assign fetch_req  = (state == FETCH) && live;
  assign fetch_addr = addr;
  assign push_valid = (state == PUSH);
  assign push_data  = acc;
  assign advance    = (state == FETCH) && (!live || fetch_ack);

  push_byte_packer #(
    .WORD_W      (WORD_W),
    .FETCH_BYTES (FETCH_BYTES),
    .PC_W        (PC_W)
  ) u_packer (
    .acc        (acc),
    .fetch_data (fetch_data),
    .c          (c),
    .addr       (addr),
    .code_size  (code_sz),
    .acc_nxt    (acc_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rem     <= '0;
      addr    <= '0;
      code_sz <= '0;
      acc     <= '0;
      pc_nxt  <= '0;
      gas     <= '0;
      bad_op  <= 1'b0;
    end else begin
      bad_op <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            if (!is_push(opcode)) begin
              bad_op <= 1'b1;
            end else begin
              acc     <= '0;
              code_sz <= code_size;
              addr    <= pc + PC_W'(1);
              rem     <= n_in;
              pc_nxt  <= pc + PC_W'(1) + PC_W'(n_in);
              if (n_in == 6'd0) begin
                gas   <= GAS_W'(GAS_BASE);
                state <= PUSH;
              end else begin
                gas   <= GAS_W'(GAS_VERYLOW);
                state <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          if (advance) begin
            acc  <= acc_nxt;
            addr <= addr + PC_W'(c);
            rem  <= rem - 6'(c);
            if (rem == 6'(c))
              state <= PUSH;
          end
        end
        PUSH: begin
          if (push_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evm_push_fetch.sv
// Bench for evm_push_fetch: table vectors, corner sequences and random ops
// checked against a byte-level reference model; a WORD_W=64 copy runs alongside.
module tb_evm_push_fetch;

  localparam int WW = 256;
  localparam int FB = 4;
  localparam int PW = 16;
  localparam int GW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [7:0]    opcode;
  logic [PW-1:0] pc;
  logic [PW-1:0] code_size;
  logic          fetch_req;
  logic [PW-1:0] fetch_addr;
  logic          fetch_ack;
  logic [8*FB-1:0] fetch_data;
  logic          push_valid;
  logic          push_ready;
  logic [WW-1:0] push_data;
  logic [PW-1:0] pc_nxt;
  logic [GW-1:0] gas;
  logic          bad_op;

  logic          op_ready64, fetch_req64, push_valid64, bad_op64;
  logic [PW-1:0] fetch_addr64, pc_nxt64;
  logic [63:0]   push_data64;
  logic [GW-1:0] gas64;

  evm_push_fetch #(.WORD_W(WW), .FETCH_BYTES(FB), .PC_W(PW), .GAS_W(GW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .pc(pc), .code_size(code_size),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .push_valid(push_valid), .push_ready(push_ready),
    .push_data(push_data), .pc_nxt(pc_nxt), .gas(gas), .bad_op(bad_op)
  );

  evm_push_fetch #(.WORD_W(64), .FETCH_BYTES(FB), .PC_W(PW), .GAS_W(GW)) dut64 (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready64),
    .opcode(opcode), .pc(pc), .code_size(code_size),
    .fetch_req(fetch_req64), .fetch_addr(fetch_addr64), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .push_valid(push_valid64), .push_ready(push_ready),
    .push_data(push_data64), .pc_nxt(pc_nxt64), .gas(gas64), .bad_op(bad_op64)
  );

  int nerr = 0;
  int nchk = 0;

  logic [7:0]    code [0:65535];
  int            ack_delay = 0;
  int            wait_cnt = 0;
  bit            spur_en = 0;
  bit            stab_err = 0;
  logic [PW-1:0] held_addr;
  logic [PW-1:0] got_addrs[$];
  logic [PW-1:0] exp_addrs[$];

  // memory responder: drives ack on the falling edge after ack_delay waits
  always @(negedge clk) begin
    if (fetch_req === 1'b1) begin
      if (wait_cnt > 0 && fetch_addr !== held_addr) stab_err = 1;
      held_addr = fetch_addr;
      if (wait_cnt >= ack_delay) begin
        fetch_ack = 1'b1;
        for (int i = 0; i < FB; i++)
          fetch_data[8*i +: 8] = code[16'(fetch_addr + i)];
        got_addrs.push_back(fetch_addr);
        wait_cnt = 0;
      end else begin
        fetch_ack = 1'b0;
        fetch_data = $urandom;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      fetch_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      fetch_data = $urandom;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: timeout", nm);
  endtask

  // reference: immediate = bytes pc+1..pc+N big-endian, zero past code end
  function automatic void model(input logic [7:0] op, input logic [15:0] p,
                                input logic [15:0] cs, output logic [255:0] val,
                                output logic [15:0] pcn, output logic [31:0] g,
                                output int nf);
    int n;
    int rem;
    int c;
    bit lv;
    logic [15:0] a;
    n = int'(op) - 95;
    val = '0;
    for (int k = 0; k < n; k++) begin
      a = 16'(p + 1 + k);
      val[8*(n-1-k) +: 8] = (a < cs) ? code[a] : 8'h00;
    end
    pcn = 16'(p + 1 + n);
    g = (n == 0) ? 32'd2 : 32'd3;
    exp_addrs.delete();
    a = 16'(p + 1);
    rem = n;
    while (rem > 0) begin
      c = (rem < FB) ? rem : FB;
      lv = 0;
      for (int i = 0; i < c; i++)
        if (16'(a + i) < cs) lv = 1;
      if (lv) exp_addrs.push_back(a);
      a = 16'(a + c);
      rem -= c;
    end
    nf = exp_addrs.size();
  endfunction

  task automatic issue(input logic [7:0] op, input logic [15:0] p,
                       input logic [15:0] cs, input string nm);
    int t = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout({nm, " op_ready"});
    opcode = op;
    pc = p;
    code_size = cs;
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    opcode = 8'($urandom);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] p,
                        input logic [15:0] cs, input int adly, input int rdly,
                        input logic [255:0] ed, input logic [63:0] ed64,
                        input logic [15:0] epc, input logic [31:0] eg,
                        input int enf, input string nm);
    logic [255:0] mv;
    logic [15:0]  mpc;
    logic [31:0]  mg;
    int           mnf;
    int           n;
    int           lat;
    bit           good;
    bit           ok;
    bit           aok;
    model(op, p, cs, mv, mpc, mg, mnf);
    ack_delay = adly;
    got_addrs.delete();
    stab_err = 0;
    n = int'(op) - 95;
    good = (op >= 8'h5F) && (op <= 8'h7F);
    issue(op, p, cs, nm);
    chk({nm, " bad_op"}, bad_op, !good);
    if (!good) begin
      ok = 1;
      repeat (4) begin
        @(negedge clk);
        if (fetch_req !== 0 || push_valid !== 0 || bad_op !== 0 || op_ready !== 1)
          ok = 0;
      end
      chk({nm, " quiet after bad_op"}, ok, 1);
      return;
    end
    lat = 1;
    while (push_valid !== 1'b1 && lat < 300) begin
      push_ready = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      lat++;
    end
    push_ready = 1'b0;
    if (lat >= 300) begin
      timeout({nm, " push_valid"});
      return;
    end
    if (adly == 0)
      chk({nm, " latency"}, lat, (n == 0) ? 1 : (n + FB - 1) / FB + 1);
    chk({nm, " push_data"}, push_data, ed);
    chk({nm, " push_data64"}, push_data64, ed64);
    chk({nm, " pc_nxt"}, pc_nxt, epc);
    chk({nm, " gas"}, gas, eg);
    ok = 1;
    repeat (rdly) begin
      @(negedge clk);
      if (push_data !== ed || pc_nxt !== epc || gas !== eg ||
          push_valid !== 1 || op_ready !== 0)
        ok = 0;
    end
    if (rdly > 0) chk({nm, " push hold"}, ok, 1);
    push_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    push_ready = 1'b0;
    chk({nm, " ready after push"}, {op_ready, push_valid}, 2'b10);
    chk({nm, " fetch count"}, got_addrs.size(), enf);
    aok = (got_addrs.size() == exp_addrs.size());
    for (int i = 0; i < got_addrs.size() && aok; i++)
      if (got_addrs[i] !== exp_addrs[i]) aok = 0;
    chk({nm, " fetch addrs"}, aok, 1);
    if (adly > 0) chk({nm, " fetch_addr hold"}, stab_err, 0);
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [15:0]  p;
    logic [15:0]  cs;
    int           adly;
    int           rdly;
    logic [255:0] d;
    logic [63:0]  d64;
    logic [15:0]  pcn;
    logic [31:0]  g;
    int           nf;
  } vec_t;

  localparam logic [255:0] P32 =
    256'h0102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F20;

  vec_t tbl[6];

  initial begin
    logic [255:0] mv;
    logic [15:0]  mpc;
    logic [31:0]  mg;
    int           mnf;
    bit           seen;
    logic [7:0]   rop;
    logic [15:0]  rp, rcs;

    tbl[0] = '{8'h5F, 16'd10, 16'd100, 0, 0, 256'h0, 64'h0, 16'd11, 32'd2, 0};
    tbl[1] = '{8'h7F, 16'd0, 16'd100, 0, 0, P32, 64'h191A1B1C1D1E1F20, 16'd33, 32'd3, 8};
    tbl[2] = '{8'h7F, 16'd0, 16'd100, 3, 5, P32, 64'h191A1B1C1D1E1F20, 16'd33, 32'd3, 8};
    tbl[3] = '{8'h67, 16'd20, 16'd10, 0, 0, 256'h0, 64'h0, 16'd29, 32'd3, 0};
    tbl[4] = '{8'h61, 16'd3, 16'd5, 0, 0, 256'h0400, 64'h0400, 16'd6, 32'd3, 1};
    tbl[5] = '{8'h62, 16'hFFFE, 16'h0100, 0, 0, 256'h1, 64'h1, 16'h0002, 32'd3, 1};

    for (int i = 0; i < 65536; i++) code[i] = 8'(i);
    rst = 1'b1;
    op_valid = 1'b0;
    opcode = 8'h00;
    pc = '0;
    code_size = '0;
    push_ready = 1'b0;
    #1;
    chk("reset op_ready", op_ready, 1);
    chk("reset outs", {fetch_req, push_valid, bad_op}, 3'b000);
    chk("reset values", {push_data, pc_nxt, gas, fetch_addr}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].p, tbl[i].cs, tbl[i].adly, tbl[i].rdly, tbl[i].d,
             tbl[i].d64, tbl[i].pcn, tbl[i].g, tbl[i].nf, $sformatf("vec%0d", i));

    code[1] = 8'hAB;
    run_op(8'h60, 16'd0, 16'd100, 0, 0, 256'hAB, 64'hAB, 16'd2, 32'd3, 1, "push1");
    code[1] = 8'h01;
    code[9] = 8'h12;
    code[10] = 8'h34;
    run_op(8'h63, 16'd8, 16'd11, 0, 0, 256'h12340000, 64'h12340000,
           16'd13, 32'd3, 1, "push4 tail");
    code[9] = 8'h09;
    code[10] = 8'h0A;
    run_op(8'h01, 16'd0, 16'd100, 0, 0, '0, '0, '0, '0, 0, "bad 01");
    run_op(8'h80, 16'd0, 16'd100, 0, 0, '0, '0, '0, '0, 0, "bad 80");
    run_op(8'h5E, 16'd0, 16'd100, 0, 0, '0, '0, '0, '0, 0, "bad 5e");

    // reset while PUSH32 is waiting on memory
    ack_delay = 10;
    issue(8'h7F, 16'd0, 16'd100, "rst push32");
    repeat (3) @(negedge clk);
    chk("rst pre fetch_req", fetch_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst fetch_req drop", {fetch_req, fetch_req64}, 2'b00);
    chk("rst push_valid", {push_valid, push_valid64}, 2'b00);
    chk("rst op_ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (push_valid !== 0 || push_valid64 !== 0) seen = 1;
    end
    chk("rst no push", seen, 0);
    run_op(8'h61, 16'd0, 16'd100, 0, 0, 256'h0102, 64'h0102, 16'd3, 32'd3, 1, "push2 after rst");

    for (int i = 0; i < 65536; i++) code[i] = 8'($urandom);
    spur_en = 1;
    for (int k = 0; k < 200; k++) begin
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h5F + $urandom_range(0, 32));
      rp = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 63));
      rcs = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 80));
      model(rop, rp, rcs, mv, mpc, mg, mnf);
      run_op(rop, rp, rcs, $urandom_range(0, 3), $urandom_range(0, 3), mv, mv[63:0],
             mpc, mg, mnf, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
